// File: rtl/amdc_gp3io_mux_regs_if.sv
// AXI4-Lite slave bus bundle for the GP3IO mux register block.
// Carries the write address, write data, write response, read address and read data channels.
// Clock and reset are not part of the bundle; they stay as plain module ports.
//   master modport : bus initiator (drives valids, addresses, data, bready/rready)
//   slave modport  : register block (drives readies, responses, read data)
interface amdc_gp3io_mux_regs_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr;
  logic [2:0]                      s00_axi_awprot;
  logic                            s00_axi_awvalid;
  logic                            s00_axi_awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb;
  logic                            s00_axi_wvalid;
  logic                            s00_axi_wready;
  logic [1:0]                      s00_axi_bresp;
  logic                            s00_axi_bvalid;
  logic                            s00_axi_bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr;
  logic [2:0]                      s00_axi_arprot;
  logic                            s00_axi_arvalid;
  logic                            s00_axi_arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata;
  logic [1:0]                      s00_axi_rresp;
  logic                            s00_axi_rvalid;
  logic                            s00_axi_rready;

  modport master (
    output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    input  s00_axi_awready,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    input  s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    input  s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    output s00_axi_rready
  );

  modport slave (
    input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    output s00_axi_awready,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    output s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    input  s00_axi_rready
  );
endinterface

// File: rtl/amdc_gp3io_mux_regs.sv
// AXI4-Lite register block driving the device select of a GP3IO mux core.
// Register map (word index addr[3:2], addr[1:0] ignored):
//   0x00 MUX_SEL  rw [3:0]   codes >= NUM_DEVICES rejected with SLVERR
//   0x04 SCRATCH0 rw [31:0]
//   0x08 SCRATCH1 rw [31:0]
//   0x0C WR_COUNT ro [15:0]  count of OKAY writes, saturating; writes get SLVERR
// Ports:
//   s00_axi_aclk    : clock, all flops rising-edge
//   s00_axi_aresetn : synchronous active-low reset
//   axi             : AXI4-Lite slave bundle (awprot/arprot ignored)
//   mux_sel         : registered device select
//   sel_update      : one-cycle pulse after MUX_SEL changes value
// Build option: define GP3IO_MUX_WSTRB_EN to honour wstrb byte lanes on rw registers;
// otherwise wstrb is ignored and every write updates all bits.
module amdc_gp3io_mux_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned NUM_DEVICES        = 8
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  amdc_gp3io_mux_regs_if.slave axi,
  output logic [3:0]           mux_sel,
  output logic                 sel_update
);
  localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {WIdle, WHaveAw, WHaveW, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  // Holds readies low until the first edge after reset is released.
  logic ready_en_q;

  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [StrbW-1:0]              w_strb_q, w_strb_d;

  logic [3:0]                    mux_sel_q, mux_sel_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] scratch0_q, scratch0_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] scratch1_q, scratch1_d;
  logic [15:0]                   wr_count_q, wr_count_d;
  logic                          sel_update_q, sel_update_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs;
  logic commit;
  logic wr_ok;
  logic [C_S_AXI_ADDR_WIDTH-1:0] commit_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] commit_data;
  logic [StrbW-1:0]              commit_strb;
  logic [StrbW-1:0]              lane_en;

  assign axi.s00_axi_awready = ready_en_q && (w_state_q == WIdle || w_state_q == WHaveW);
  assign axi.s00_axi_wready  = ready_en_q && (w_state_q == WIdle || w_state_q == WHaveAw);
  assign axi.s00_axi_bvalid  = (w_state_q == WResp);
  assign axi.s00_axi_bresp   = bresp_q;
  assign axi.s00_axi_arready = ready_en_q && (r_state_q == RIdle);
  assign axi.s00_axi_rvalid  = (r_state_q == RData);
  assign axi.s00_axi_rdata   = rdata_q;
  assign axi.s00_axi_rresp   = rresp_q;
  assign mux_sel             = mux_sel_q;
  assign sel_update          = sel_update_q;

  assign aw_hs = axi.s00_axi_awvalid && axi.s00_axi_awready;
  assign w_hs  = axi.s00_axi_wvalid && axi.s00_axi_wready;
  assign ar_hs = axi.s00_axi_arvalid && axi.s00_axi_arready;

`ifdef GP3IO_MUX_WSTRB_EN
  assign lane_en = commit_strb;
`else
  assign lane_en = '1;
`endif

  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] merge_lanes(
    input logic [C_S_AXI_DATA_WIDTH-1:0] old_val,
    input logic [C_S_AXI_DATA_WIDTH-1:0] new_val,
    input logic [StrbW-1:0]              en
  );
    logic [C_S_AXI_DATA_WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(StrbW); i++) begin
      if (en[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Write channel: collect AW and W in either order, commit once both are held.
  always_comb begin
    w_state_d   = w_state_q;
    aw_addr_d   = aw_addr_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    commit      = 1'b0;
    commit_addr = axi.s00_axi_awaddr;
    commit_data = axi.s00_axi_wdata;
    commit_strb = axi.s00_axi_wstrb;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs && w_hs) begin
          commit    = 1'b1;
          w_state_d = WResp;
        end else if (aw_hs) begin
          aw_addr_d = axi.s00_axi_awaddr;
          w_state_d = WHaveAw;
        end else if (w_hs) begin
          w_data_d  = axi.s00_axi_wdata;
          w_strb_d  = axi.s00_axi_wstrb;
          w_state_d = WHaveW;
        end
      end
      WHaveAw: begin
        commit_addr = aw_addr_q;
        if (w_hs) begin
          commit    = 1'b1;
          w_state_d = WResp;
        end
      end
      WHaveW: begin
        commit_data = w_data_q;
        commit_strb = w_strb_q;
        if (aw_hs) begin
          commit    = 1'b1;
          w_state_d = WResp;
        end
      end
      WResp: begin
        if (axi.s00_axi_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Register file update on a committed write.
  always_comb begin
    mux_sel_d    = mux_sel_q;
    scratch0_d   = scratch0_q;
    scratch1_d   = scratch1_q;
    wr_count_d   = wr_count_q;
    sel_update_d = 1'b0;
    bresp_d      = bresp_q;
    wr_ok        = 1'b1;
    if (commit) begin
      unique case (commit_addr[3:2])
        2'd0: begin
          // A cleared lane 0 is a legal no-op write, still counted as OKAY.
          if (lane_en[0]) begin
            if ({28'd0, commit_data[3:0]} >= NUM_DEVICES) begin
              wr_ok = 1'b0;
            end else begin
              mux_sel_d    = commit_data[3:0];
              sel_update_d = (commit_data[3:0] != mux_sel_q);
            end
          end
        end
        2'd1: scratch0_d = merge_lanes(scratch0_q, commit_data, lane_en);
        2'd2: scratch1_d = merge_lanes(scratch1_q, commit_data, lane_en);
        default: wr_ok = 1'b0;
      endcase
      bresp_d = wr_ok ? RespOkay : RespSlvErr;
      if (wr_ok && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
    end
  end

  // Read channel: sample the pre-commit register values on the AR handshake.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          unique case (axi.s00_axi_araddr[3:2])
            2'd0:    rdata_d = {{(C_S_AXI_DATA_WIDTH-4){1'b0}}, mux_sel_q};
            2'd1:    rdata_d = scratch0_q;
            2'd2:    rdata_d = scratch1_q;
            default: rdata_d = {{(C_S_AXI_DATA_WIDTH-16){1'b0}}, wr_count_q};
          endcase
          rresp_d   = RespOkay;
          r_state_d = RData;
        end
      end
      RData: begin
        if (axi.s00_axi_rready) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      w_state_q    <= WIdle;
      r_state_q    <= RIdle;
      ready_en_q   <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      mux_sel_q    <= '0;
      scratch0_q   <= '0;
      scratch1_q   <= '0;
      wr_count_q   <= '0;
      sel_update_q <= 1'b0;
      bresp_q      <= '0;
      rdata_q      <= '0;
      rresp_q      <= '0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      ready_en_q   <= 1'b1;
      aw_addr_q    <= aw_addr_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      mux_sel_q    <= mux_sel_d;
      scratch0_q   <= scratch0_d;
      scratch1_q   <= scratch1_d;
      wr_count_q   <= wr_count_d;
      sel_update_q <= sel_update_d;
      bresp_q      <= bresp_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
    end
  end

  logic unused_sig;
  assign unused_sig = ^{axi.s00_axi_awprot, axi.s00_axi_arprot, axi.s00_axi_araddr[1:0],
                        commit_addr[1:0], commit_strb};
endmodule

// File: tb/tb_amdc_gp3io_mux_regs.sv
module tb_amdc_gp3io_mux_regs;
  localparam logic [1:0] Okay   = 2'b00;
  localparam logic [1:0] SlvErr = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  amdc_gp3io_mux_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) axi ();
  logic [3:0] mux_sel;
  logic       sel_update;

  amdc_gp3io_mux_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .NUM_DEVICES(8)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_aresetn(rst_n),
    .axi(axi.slave),
    .mux_sel(mux_sel),
    .sel_update(sel_update)
  );

  int n_checks = 0;
  int n_errors = 0;
  int sel_pulses = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got event expected none/timely", name);
  endtask

  // Scoreboard monitor: pops an expectation whenever a response handshake happens.
  always @(negedge clk) begin
    if (rst_n) begin
      if (axi.s00_axi_bvalid && axi.s00_axi_bready) begin
        if (exp_b_q.size() == 0) fail_now("unexpected_b");
        else check("bresp", {30'd0, axi.s00_axi_bresp}, {30'd0, exp_b_q.pop_front()});
      end
      if (axi.s00_axi_rvalid && axi.s00_axi_rready) begin
        if (exp_r_q.size() == 0) begin
          fail_now("unexpected_r");
        end else begin
          logic [33:0] e;
          e = exp_r_q.pop_front();
          check("rdata", axi.s00_axi_rdata, e[31:0]);
          check("rresp", {30'd0, axi.s00_axi_rresp}, {30'd0, e[33:32]});
        end
      end
    end
  end

  always @(negedge clk) if (sel_update === 1'b1) sel_pulses++;

  // lead > 0: W issued that many cycles before AW; lead < 0: AW leads.
  task automatic wr_issue(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead);
    int  aw_start, w_start;
    bit  aw_done, w_done, aw_hs, w_hs;
    aw_done  = 1'b0;
    w_done   = 1'b0;
    aw_start = (lead < 0) ? 0 : lead;
    w_start  = (lead > 0) ? 0 : -lead;
    axi.s00_axi_awaddr = addr;
    axi.s00_axi_wdata  = data;
    axi.s00_axi_wstrb  = strb;
    for (int cyc = 0; !(aw_done && w_done); cyc++) begin
      if (cyc >= 40) begin
        fail_now("write_handshake_timeout");
        break;
      end
      if (cyc == aw_start) axi.s00_axi_awvalid = 1'b1;
      if (cyc == w_start)  axi.s00_axi_wvalid  = 1'b1;
      @(negedge clk);
      if (cyc < aw_start || cyc < w_start) check("bvalid_before_both", {31'd0, axi.s00_axi_bvalid}, 0);
      aw_hs = axi.s00_axi_awvalid && axi.s00_axi_awready;
      w_hs  = axi.s00_axi_wvalid && axi.s00_axi_wready;
      @(posedge clk);
      #1;
      if (aw_hs) begin axi.s00_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin axi.s00_axi_wvalid  = 1'b0; w_done  = 1'b1; end
    end
    axi.s00_axi_awvalid = 1'b0;
    axi.s00_axi_wvalid  = 1'b0;
  endtask

  task automatic wr_wait_b();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (axi.s00_axi_bvalid && axi.s00_axi_bready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_now("bresp_timeout");
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input logic [1:0] resp);
    exp_b_q.push_back(resp);
    wr_issue(addr, data, strb, lead);
    wr_wait_b();
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [31:0] exp, input int rhold);
    bit hs;
    bit got;
    exp_r_q.push_back({Okay, exp});
    if (rhold > 0) axi.s00_axi_rready = 1'b0;
    axi.s00_axi_araddr  = addr;
    axi.s00_axi_arvalid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 40 && !hs; i++) begin
      @(negedge clk);
      hs = axi.s00_axi_arvalid && axi.s00_axi_arready;
      if (hs) check("rvalid_before_ar", {31'd0, axi.s00_axi_rvalid}, 0);
      @(posedge clk);
      #1;
    end
    axi.s00_axi_arvalid = 1'b0;
    if (!hs) begin
      fail_now("ar_timeout");
      axi.s00_axi_rready = 1'b1;
      return;
    end
    @(negedge clk);
    check("rvalid_latency", {31'd0, axi.s00_axi_rvalid}, 1);
    for (int k = 0; k < rhold; k++) begin
      check("rvalid_hold", {31'd0, axi.s00_axi_rvalid}, 1);
      check("rdata_hold", axi.s00_axi_rdata, exp);
      @(negedge clk);
    end
    if (rhold > 0) begin
      @(posedge clk);
      #1;
      axi.s00_axi_rready = 1'b1;
      @(negedge clk);
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (axi.s00_axi_rvalid && axi.s00_axi_rready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) fail_now("r_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_strb;
    axi.s00_axi_awaddr  = '0;
    axi.s00_axi_awprot  = '0;
    axi.s00_axi_awvalid = 1'b0;
    axi.s00_axi_wdata   = '0;
    axi.s00_axi_wstrb   = '0;
    axi.s00_axi_wvalid  = 1'b0;
    axi.s00_axi_bready  = 1'b1;
    axi.s00_axi_araddr  = '0;
    axi.s00_axi_arprot  = '0;
    axi.s00_axi_arvalid = 1'b0;
    axi.s00_axi_rready  = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'd0, axi.s00_axi_awready}, 0);
    check("rst_wready", {31'd0, axi.s00_axi_wready}, 0);
    check("rst_arready", {31'd0, axi.s00_axi_arready}, 0);
    check("rst_bvalid", {31'd0, axi.s00_axi_bvalid}, 0);
    check("rst_rvalid", {31'd0, axi.s00_axi_rvalid}, 0);
    check("rst_bresp", {30'd0, axi.s00_axi_bresp}, 0);
    check("rst_rdata", axi.s00_axi_rdata, 0);
    check("rst_mux_sel", {28'd0, mux_sel}, 0);
    check("rst_sel_update", {31'd0, sel_update}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("awready_before_first_edge", {31'd0, axi.s00_axi_awready}, 0);
    @(posedge clk);
    #1;

    // Same-cycle AW/W write of a legal select.
    sel_pulses = 0;
    do_write(4'h0, 32'h3, 4'hF, 0, Okay);
    check("mux_sel_3", {28'd0, mux_sel}, 3);
    check("sel_pulse_once", sel_pulses, 1);
    do_read(4'hC, 32'd1, 0);
    do_read(4'h0, 32'd3, 0);

    // W leads AW by three cycles.
    do_write(4'h4, 32'hDEADBEEF, 4'hF, 3, Okay);
    do_read(4'h4, 32'hDEADBEEF, 0);

    // Out-of-range select and repeat of the current select.
    sel_pulses = 0;
    do_write(4'h0, 32'h9, 4'hF, 0, SlvErr);
    check("mux_sel_after_slverr", {28'd0, mux_sel}, 3);
    do_read(4'hC, 32'd2, 0);
    do_write(4'h0, 32'h3, 4'hF, 0, Okay);
    check("no_pulse_same_or_err", sel_pulses, 0);

    // WR_COUNT is read-only.
    do_write(4'hC, 32'h5, 4'hF, 0, SlvErr);
    do_read(4'hC, 32'd3, 0);

    // Partial byte-lane write.
    do_write(4'h8, 32'h11223344, 4'hF, 0, Okay);
    do_write(4'h8, 32'hAABBCCDD, 4'b0101, 0, Okay);
`ifdef GP3IO_MUX_WSTRB_EN
    exp_strb = 32'h11BB33DD;
`else
    exp_strb = 32'hAABBCCDD;
`endif
    do_read(4'h8, exp_strb, 0);

    // Write response back-pressure; addr[1:0] ignored.
    axi.s00_axi_bready = 1'b0;
    exp_b_q.push_back(Okay);
    wr_issue(4'h5, 32'h12345678, 4'hF, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bvalid_hold", {31'd0, axi.s00_axi_bvalid}, 1);
      check("bresp_hold", {30'd0, axi.s00_axi_bresp}, 0);
      check("awready_in_resp", {31'd0, axi.s00_axi_awready}, 0);
      check("wready_in_resp", {31'd0, axi.s00_axi_wready}, 0);
    end
    @(posedge clk);
    #1;
    axi.s00_axi_bready = 1'b1;
    wr_wait_b();
    do_read(4'h4, 32'h12345678, 5);
    do_read(4'hC, 32'd6, 0);

    // AW leads W; highest legal code, then first illegal code.
    sel_pulses = 0;
    do_write(4'h0, 32'h7, 4'hF, -2, Okay);
    check("mux_sel_7", {28'd0, mux_sel}, 7);
    check("sel_pulse_7", sel_pulses, 1);
    do_write(4'h0, 32'h8, 4'hF, 0, SlvErr);
    check("mux_sel_after_8", {28'd0, mux_sel}, 7);

    // Read captured on the same edge as a write commit returns the old value.
    fork
      do_write(4'h4, 32'hCAFE0000, 4'hF, 0, Okay);
      do_read(4'h4, 32'h12345678, 0);
    join
    do_read(4'h4, 32'hCAFE0000, 0);
    do_read(4'hC, 32'd8, 0);

    // Reset while the write response is pending.
    axi.s00_axi_bready = 1'b0;
    wr_issue(4'h8, 32'h1, 4'hF, 0);
    @(negedge clk);
    check("bvalid_before_reset", {31'd0, axi.s00_axi_bvalid}, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bvalid_after_reset", {31'd0, axi.s00_axi_bvalid}, 0);
    check("mux_sel_after_reset", {28'd0, mux_sel}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    axi.s00_axi_bready = 1'b1;
    do_read(4'hC, 32'd0, 0);
    do_read(4'h8, 32'd0, 0);
    do_read(4'h4, 32'd0, 0);
    sel_pulses = 0;
    do_write(4'h0, 32'h2, 4'hF, 0, Okay);
    check("mux_sel_2", {28'd0, mux_sel}, 2);
    check("sel_pulse_2", sel_pulses, 1);
    do_read(4'hC, 32'd1, 0);

    repeat (2) @(posedge clk);
    check("b_queue_drained", exp_b_q.size(), 0);
    check("r_queue_drained", exp_r_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/amdc_gp3io_mux_regs.md
AMDC_GP3IO_MUX_REGS -- requirements
Module: amdc_gp3io_mux_regs

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4, AXI4-Lite byte-address width.
REQ-003 Parameter NUM_DEVICES, default 8, number of legal mux select codes (1..16).
REQ-004 s00_axi_aclk  in  1  sole clock; every flop is rising-edge on it.
REQ-005 s00_axi_aresetn  in  1  reset; synchronous, active-low.
REQ-006 s00_axi_awaddr/awprot/awvalid in, awready out  4/3/1/1  AXI4-Lite write address channel; awprot ignored.
REQ-007 s00_axi_wdata/wstrb/wvalid in, wready out  32/4/1/1  AXI4-Lite write data channel.
REQ-008 s00_axi_bresp/bvalid out, bready in  2/1/1  AXI4-Lite write response channel.
REQ-009 s00_axi_araddr/arprot/arvalid in, arready out  4/3/1/1  AXI4-Lite read address channel; arprot ignored.
REQ-010 s00_axi_rdata/rresp/rvalid out, rready in  32/2/1/1  AXI4-Lite read data channel.
REQ-011 mux_sel  out  4  registered device select driven to the downstream GP3IO mux core.
REQ-012 sel_update  out  1  one-cycle pulse when mux_sel changes value.

Function
REQ-013 Register map, word index addr[3:2]: 0x00 MUX_SEL rw [3:0], 0x04 SCRATCH0 rw [31:0], 0x08 SCRATCH1 rw [31:0], 0x0C WR_COUNT ro [15:0]; unused bits read 0; addr[1:0] ignored.
REQ-014 Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-015 In W_IDLE, awready=1 and wready=1; AW-only handshake -> W_HAVE_AW; W-only -> W_HAVE_W; both in same cycle -> register write and W_RESP on the next edge.
REQ-016 In W_HAVE_AW only wready=1; in W_HAVE_W only awready=1; completing handshake performs the write and enters W_RESP.
REQ-017 In W_RESP, awready=wready=0 and bvalid=1, held with stable bresp until bready=1, then W_IDLE; bvalid&bready does not re-accept AW/W in the same cycle.
REQ-018 Write to MUX_SEL with wdata[3:0] >= NUM_DEVICES: register unchanged, bresp=SLVERR (2'b10); all other writes bresp=OKAY.
REQ-019 Write to WR_COUNT: no register change, bresp=SLVERR.
REQ-020 WR_COUNT increments by 1 on every write completing with OKAY; saturates at 16'hFFFF.
REQ-021 mux_sel equals MUX_SEL[3:0]; sel_update=1 for exactly the cycle after an OKAY MUX_SEL write whose new value differs from the old; rewriting the same value gives no pulse.
REQ-022 Read FSM states: R_IDLE (arready=1), R_DATA (rvalid=1, arready=0); AR handshake latches rdata/rresp=OKAY and enters R_DATA next edge; holds until rready=1, then R_IDLE.
REQ-023 Read latency: rvalid asserts exactly 1 cycle after AR handshake; rdata stable while rvalid=1 and rready=0.
REQ-024 Read and write channels independent; a read captured in the same cycle as a write commit to the same register returns the pre-write value.

Reset
REQ-025 While s00_axi_aresetn=0 at a rising edge: both FSMs to idle; awready, wready, arready, bvalid, rvalid, sel_update = 0; bresp, rresp, rdata = 0; all registers and mux_sel = 0.
REQ-026 Ready signals assert no earlier than the first edge after reset deasserts; a transaction in flight when reset asserts is discarded without response.

Configuration
REQ-027 Macro GP3IO_MUX_WSTRB_EN defined: each byte lane of a rw register is written only if its wstrb bit is 1; a MUX_SEL write with wstrb[0]=0 leaves MUX_SEL unchanged, returns OKAY, and increments WR_COUNT.
REQ-028 GP3IO_MUX_WSTRB_EN undefined: wstrb ignored; every write updates all 32 bits.

Verification
REQ-029 Reset, then write 0x3 to 0x00 with AW and W same cycle -> bresp OKAY, mux_sel=3, sel_update single pulse, WR_COUNT read =1.
REQ-030 W presented 3 cycles before AW, data 0xDEADBEEF to 0x04 -> write completes only after AW; readback 0x04 = 0xDEADBEEF, rvalid 1 cycle after AR handshake.
REQ-031 Write 0x9 to 0x00 with NUM_DEVICES=8 -> bresp SLVERR, mux_sel unchanged, no sel_update, WR_COUNT unchanged.
REQ-032 bready held 0 for 5 cycles -> bvalid and bresp stable, awready/wready 0; rready held 0 for 5 cycles -> rvalid/rdata stable.
REQ-033 With GP3IO_MUX_WSTRB_EN: 0x08 holds 0x11223344, write 0xAABBCCDD wstrb=4'b0101 -> readback 0x11BB33DD; without macro -> 0xAABBCCDD.
REQ-034 Reset asserted while in W_RESP -> bvalid=0 next edge, all registers 0, next write of 0x2 to 0x00 succeeds with mux_sel=2.
